// File: rtl/pc_unit_if.sv
// Fetch-side bundle between the PC unit and its control source: redirect controls in,
// current instruction address and return-stack status out.
interface pc_unit_if #(
  parameter int WIDTH = 16
);
  logic             hit;
  logic             branchTaken;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] branchTarget;
  logic [WIDTH-1:0] instAddrResult;
  logic             rasEmpty;
  logic             rasFull;
  logic             rasOverflow;
  logic             rasUnderflow;
  logic [15:0]      redirCount;

  modport master (
    output hit, branchTaken, call, ret, branchTarget,
    input  instAddrResult, rasEmpty, rasFull, rasOverflow, rasUnderflow, redirCount
  );

  modport slave (
    input  hit, branchTaken, call, ret, branchTarget,
    output instAddrResult, rasEmpty, rasFull, rasOverflow, rasUnderflow, redirCount
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with circular return-address stack; all state moves on the falling clock edge.
// Optional redirect performance counter enabled by defining PC_UNIT_PERF_EN.
module pc_unit #(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = 1,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}}
) (
  input  logic     clk,
  input  logic     resetN,
  pc_unit_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_top;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [PW-1:0]    w_top_inc;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_unf_set;

  assign w_seq     = r_pc + WIDTH'(STEP);
  assign w_top_inc = r_top + PW'(1);
  assign w_full    = (r_cnt == CW'(RAS_DEPTH));
  assign w_empty   = (r_cnt == {CW{1'b0}});

  // Next-state selection, ret > call > branchTaken > sequential
  always_comb begin
    w_pc_nxt  = w_seq;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (bus.ret) begin
      if (!w_empty) begin
        w_pc_nxt = r_ras[r_top];
        w_pop    = 1'b1;
      end else begin
        w_unf_set = 1'b1;
      end
    end else if (bus.call) begin
      w_pc_nxt  = bus.branchTarget;
      w_push    = 1'b1;
      w_ovf_set = w_full;
    end else if (bus.branchTaken) begin
      w_pc_nxt = bus.branchTarget;
    end else begin
      w_pc_nxt = w_seq;
    end
  end

  // PC, stack pointer/count and sticky flags; hit=0 freezes everything
  always_ff @(negedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pc  <= RESET_VEC;
      r_top <= {PW{1'b0}};
      r_cnt <= {CW{1'b0}};
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (bus.hit) begin
      r_pc <= w_pc_nxt;
      if (w_push) begin
        // When full the incremented pointer lands on the oldest entry, overwriting it
        r_top <= w_top_inc;
        if (!w_full) begin
          r_cnt <= r_cnt + CW'(1);
        end else begin
          r_cnt <= r_cnt;
        end
      end else if (w_pop) begin
        r_top <= r_top - PW'(1);
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_top <= r_top;
        r_cnt <= r_cnt;
      end
      r_ovf <= r_ovf | w_ovf_set;
      r_unf <= r_unf | w_unf_set;
    end else begin
      r_pc  <= r_pc;
      r_top <= r_top;
      r_cnt <= r_cnt;
      r_ovf <= r_ovf;
      r_unf <= r_unf;
    end
  end

  // Stack storage carries no reset; only the slot at the new top is written
  always_ff @(negedge clk) begin
    if (resetN && bus.hit && w_push) begin
      r_ras[w_top_inc] <= w_seq;
    end
  end

`ifdef PC_UNIT_PERF_EN
  logic [15:0] r_redir;
  logic        w_redir;

  assign w_redir = (bus.ret && !w_empty) || bus.call || bus.branchTaken;

  // Saturating count of accepted redirects
  always_ff @(negedge clk or negedge resetN) begin
    if (!resetN) begin
      r_redir <= 16'h0000;
    end else if (bus.hit && w_redir && (r_redir != 16'hFFFF)) begin
      r_redir <= r_redir + 16'h0001;
    end else begin
      r_redir <= r_redir;
    end
  end

  assign bus.redirCount = r_redir;
`else
  assign bus.redirCount = 16'h0000;
`endif

  assign bus.instAddrResult = r_pc;
  assign bus.rasEmpty       = w_empty;
  assign bus.rasFull        = w_full;
  assign bus.rasOverflow    = r_ovf;
  assign bus.rasUnderflow   = r_unf;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic against a
// queue-based return-stack model.
module tb_pc_unit;
  localparam int DEPTH = 4;

  logic clk;
  logic resetN;
  int   n_tests;
  int   n_fail;

  pc_unit_if #(.WIDTH(16)) bus_if ();

  pc_unit #(
    .WIDTH    (16),
    .STEP     (1),
    .RAS_DEPTH(DEPTH),
    .RESET_VEC(16'h0000)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus_if)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Reference model
  logic [15:0] m_pc;
  logic [15:0] m_ras[$];
  logic        m_ovf;
  logic        m_unf;
  int          m_redir;

  function automatic logic [15:0] exp_redir();
`ifdef PC_UNIT_PERF_EN
    return 16'(m_redir);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    m_pc    = 16'h0000;
    m_ras   = {};
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_redir = 0;
  endtask

  task automatic model_step(input logic h, input logic b, input logic c, input logic r,
                            input logic [15:0] t);
    logic [15:0] seq;
    logic        redir;
    if (!h) return;
    seq   = m_pc + 16'd1;
    redir = 1'b1;
    if (r) begin
      if (m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else begin
        m_pc  = seq;
        m_unf = 1'b1;
        redir = 1'b0;
      end
    end else if (c) begin
      if (m_ras.size() == DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_ras.push_back(seq);
      m_pc = t;
    end else if (b) begin
      m_pc = t;
    end else begin
      m_pc  = seq;
      redir = 1'b0;
    end
    if (redir && m_redir < 65535) m_redir++;
  endtask

  // Drive one cycle: inputs set between edges, update at negedge, sample 2 time units later
  task automatic do_cycle(input logic h, input logic b, input logic c, input logic r,
                          input logic [15:0] t);
    bus_if.hit          = h;
    bus_if.branchTaken  = b;
    bus_if.call         = c;
    bus_if.ret          = r;
    bus_if.branchTarget = t;
    @(negedge clk);
    model_step(h, b, c, r, t);
    #2;
  endtask

  task automatic apply_reset();
    resetN = 1'b0;
    bus_if.hit = 1'b0; bus_if.branchTaken = 1'b0; bus_if.call = 1'b0; bus_if.ret = 1'b0;
    bus_if.branchTarget = 16'h0000;
    model_reset();
    @(negedge clk);
    #2;
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (bus_if.instAddrResult !== 16'h0000 || bus_if.rasEmpty !== 1'b1 || bus_if.rasFull !== 1'b0 ||
        bus_if.rasOverflow !== 1'b0 || bus_if.rasUnderflow !== 1'b0 || bus_if.redirCount !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h empty=%b full=%b ovf=%b unf=%b cnt=%h required pc=0000 empty=1 full=0 ovf=0 unf=0 cnt=0000",
               bus_if.instAddrResult, bus_if.rasEmpty, bus_if.rasFull, bus_if.rasOverflow,
               bus_if.rasUnderflow, bus_if.redirCount);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc;
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      exp_pc = 16'(i);
      n_tests++;
      if (bus_if.instAddrResult !== exp_pc) begin
        n_fail++;
        $display("FAIL seq_%0d: pc=%h required %h", i, bus_if.instAddrResult, exp_pc);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0040);
    n_tests++;
    if (bus_if.instAddrResult !== 16'h0005) begin
      n_fail++;
      $display("FAIL stall_hold: pc=%h required 0005", bus_if.instAddrResult);
    end
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040);
    n_tests++;
    if (bus_if.instAddrResult !== 16'h0040) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h required 0040", bus_if.instAddrResult);
    end
  endtask

  task automatic test_call_ret();
    apply_reset();
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0100);
    n_tests++;
    if (bus_if.instAddrResult !== 16'h0100 || bus_if.rasEmpty !== 1'b0) begin
      n_fail++;
      $display("FAIL call: pc=%h empty=%b required pc=0100 empty=0", bus_if.instAddrResult, bus_if.rasEmpty);
    end
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h7777);
    n_tests++;
    if (bus_if.instAddrResult !== 16'h0011 || bus_if.rasEmpty !== 1'b1) begin
      n_fail++;
      $display("FAIL ret: pc=%h empty=%b required pc=0011 empty=1", bus_if.instAddrResult, bus_if.rasEmpty);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_ret [4];
    exp_ret[0] = 16'h0401; exp_ret[1] = 16'h0301; exp_ret[2] = 16'h0201; exp_ret[3] = 16'h0101;
    apply_reset();
    for (int i = 1; i <= 5; i++) do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'(i * 256));
    n_tests++;
    if (bus_if.rasFull !== 1'b1 || bus_if.rasOverflow !== 1'b1 || bus_if.instAddrResult !== 16'h0500) begin
      n_fail++;
      $display("FAIL overflow: full=%b ovf=%b pc=%h required full=1 ovf=1 pc=0500",
               bus_if.rasFull, bus_if.rasOverflow, bus_if.instAddrResult);
    end
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
      n_tests++;
      if (bus_if.instAddrResult !== exp_ret[i]) begin
        n_fail++;
        $display("FAIL nested_ret_%0d: pc=%h required %h", i, bus_if.instAddrResult, exp_ret[i]);
      end
    end
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    n_tests++;
    if (bus_if.instAddrResult !== 16'h0102 || bus_if.rasUnderflow !== 1'b1 || bus_if.rasOverflow !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: pc=%h unf=%b ovf=%b required pc=0102 unf=1 ovf=1",
               bus_if.instAddrResult, bus_if.rasUnderflow, bus_if.rasOverflow);
    end
  endtask

  task automatic test_wrap_combo();
    apply_reset();
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_tests++;
    if (bus_if.instAddrResult !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap: pc=%h required 0000", bus_if.instAddrResult);
    end
    do_cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    n_tests++;
    if (bus_if.instAddrResult !== 16'h0001 || bus_if.rasUnderflow !== 1'b1 || bus_if.rasEmpty !== 1'b1) begin
      n_fail++;
      $display("FAIL combo_empty: pc=%h unf=%b empty=%b required pc=0001 unf=1 empty=1",
               bus_if.instAddrResult, bus_if.rasUnderflow, bus_if.rasEmpty);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0200);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0300);
    #1;
    resetN = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (bus_if.instAddrResult !== 16'h0000 || bus_if.rasEmpty !== 1'b1 || bus_if.rasUnderflow !== 1'b0 ||
        bus_if.rasOverflow !== 1'b0 || bus_if.redirCount !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h empty=%b unf=%b ovf=%b cnt=%h required pc=0000 empty=1 unf=0 ovf=0 cnt=0000",
               bus_if.instAddrResult, bus_if.rasEmpty, bus_if.rasUnderflow, bus_if.rasOverflow,
               bus_if.redirCount);
    end
    #1;
    resetN = 1'b1;
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    n_tests++;
    if (bus_if.instAddrResult !== 16'h0001) begin
      n_fail++;
      $display("FAIL post_reset_seq: pc=%h required 0001", bus_if.instAddrResult);
    end
  endtask

  task automatic test_perf();
    logic [15:0] exp_cnt;
    apply_reset();
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0020);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0080);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0999);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
`ifdef PC_UNIT_PERF_EN
    exp_cnt = 16'h0003;
`else
    exp_cnt = 16'h0000;
`endif
    n_tests++;
    if (bus_if.redirCount !== exp_cnt) begin
      n_fail++;
      $display("FAIL perf_count: redirCount=%h required %h", bus_if.redirCount, exp_cnt);
    end
  endtask

  task automatic test_random();
    logic        h, b, c, r;
    logic [15:0] t;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      h = ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) == 0);
      t = 16'($urandom);
      do_cycle(h, b, c, r, t);
      n_tests++;
      if (bus_if.instAddrResult !== m_pc ||
          bus_if.rasEmpty !== (m_ras.size() == 0) ||
          bus_if.rasFull !== (m_ras.size() == DEPTH) ||
          bus_if.rasOverflow !== m_ovf || bus_if.rasUnderflow !== m_unf ||
          bus_if.redirCount !== exp_redir()) begin
        n_fail++;
        $display("FAIL random_%0d: pc=%h empty=%b full=%b ovf=%b unf=%b cnt=%h required pc=%h depth=%0d ovf=%b unf=%b cnt=%h",
                 i, bus_if.instAddrResult, bus_if.rasEmpty, bus_if.rasFull, bus_if.rasOverflow,
                 bus_if.rasUnderflow, bus_if.redirCount, m_pc, m_ras.size(), m_ovf, m_unf, exp_redir());
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetN  = 1'b0;
    bus_if.hit = 1'b0; bus_if.branchTaken = 1'b0; bus_if.call = 1'b0; bus_if.ret = 1'b0;
    bus_if.branchTarget = 16'h0000;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_call_ret();
    test_overflow();
    test_wrap_combo();
    test_async_reset();
    test_perf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
